diffl: RTL and testbench
========================

Name: diffl

Overview:
- Fixed-point modular differentiator (comb section), the inverse of the accumulator `accuml`.
- Computes Q = D[n] - D[n-DELAY] modulo 2^(WIDTH+1) on each valid sample.
- Feeding `accuml` Q into this block with DELAY=1 recovers the original `accuml` D stream exactly, including across wrap-around.
- Used as the comb stage after integrator stages in decimators, and as the loopback checker for accumulator-based phase generators.

Parameters:
- WIDTH, 16, sample width of the matching accumulator input; data path is WIDTH+1 bits.
- DELAY, 1, differential delay M in samples; legal range 1..16.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- clr  input  1  synchronous clear of history, fill count and output.
- add_sub  input  1  0: Q = D - hist; 1: Q = hist - D (inverse of a subtracting accumulator).
- in_valid  input  1  D is a valid sample this cycle.
- D  input  WIDTH+1  input sample, unsigned modular.
- out_valid  output  1  Q holds a new result this cycle.
- Q  output  WIDTH+1  difference result, modulo 2^(WIDTH+1).
- primed  output  1  high once DELAY samples have been absorbed since reset/clr.

Behaviour:
- Reset (async, active-high): Q=0, out_valid=0, primed=0, all history entries 0, fill count 0, write pointer 0, state EMPTY.
- History is a circular buffer of DELAY entries, WIDTH+1 bits each.
  - hist = entry at the write pointer, i.e. the sample DELAY valid samples ago; 0 if never written since reset/clr.
  - On an accepted sample, D overwrites that entry.
  - The pointer increments and wraps DELAY-1 -> 0.
- Accepted sample = in_valid & ~clr.
- Latency 1: for an accepted sample at edge k:
  - Q at k+1 = (add_sub ? hist - D : D - hist) truncated to WIDTH+1 bits; no saturation, no sign extension.
  - out_valid=1 for exactly that one cycle.
- in_valid=0: history, pointer and fill count hold; Q holds its last value; out_valid=0.
- State machine:
  - EMPTY -> FILLING on the first accepted sample; if DELAY=1, EMPTY -> PRIMED directly.
  - FILLING -> PRIMED when fill count reaches DELAY.
  - PRIMED stays until clr or reset.
  - clr in any state -> EMPTY.
  - Fill count saturates at DELAY.
  - primed = (state == PRIMED), registered; it rises in the same cycle as the out_valid of the DELAY-th sample.
- Results produced before primed use hist=0, so Q = ±D. They are still flagged out_valid; downstream gates on primed if required.
- clr (sync):
  - Next edge: history=0, pointer=0, fill count=0, Q=0, out_valid=0, primed=0.
  - clr has priority over in_valid; the sample presented in that cycle is discarded.
- add_sub may change per sample; it applies to the sample accepted with it, and history is unaffected.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronously); no partial result is emitted after release.

Decomposition:
- Shared package `fxp_pkg`:
  - constants DIFFL_MAX_DELAY=16;
  - state enum {EMPTY, FILLING, PRIMED};
  - function clog2 for pointer and fill-count widths (min 1 bit).
- One sub-module, `diffl_delay`: circular buffer with write pointer and read-before-write of the oldest entry.
  - Ports: clock, reset, clr, wr_en, din, dout.
- The top holds the FSM, fill counter, subtractor and output registers.

Test Plan:
- Step 1, ramp, WIDTH=16, DELAY=1, add_sub=0: D=10000,20000,30000 consecutive -> Q=10000,10000,10000 one cycle later each; out_valid high 3 cycles; primed high from first result.
- Step 2, wrap, same config: D=130000 then 8928 -> second Q=10000, since (8928-130000) mod 131072 = 10000.
- Step 3, subtract mode: add_sub=1, history 0, D=10000 -> Q=121072; next D=20000 with add_sub=1 -> Q=121072.
- Step 4, DELAY=4 with gaps: D=0,1,2,…,7 with in_valid toggling 1,0 each cycle.
  - Q=0,1,2,3,4,4,4,4.
  - primed rises with the 4th result.
  - out_valid is never high two cycles in a row.
- Step 5, clr collision, DELAY=1, mid-stream at D=50000: clr=1 with in_valid=1, D=60000.
  - Next cycle: out_valid=0, Q=0, primed=0.
  - Next accepted D=70000 -> Q=70000.
- Step 6, loopback and reset: `accuml` output (D steps 10000/5000/2000, clr pulses) drives diffl with DELAY=1.
  - After each clr, diffl Q matches the `accuml` input per sample.
  - Reset asserted mid-stream forces Q=0, out_valid=0, primed=0 within the same cycle.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: delay limits, differentiator FSM states and a
// width helper for pointers and counters.
package fxp_pkg;

  localparam int DIFFL_MAX_DELAY = 16;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    PRIMED
  } diffl_state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/diffl_delay.sv
// Circular history buffer for the differentiator. dout is the entry at the
// write pointer, i.e. the sample written DELAY writes ago (0 if never written).
// A write replaces that entry and advances the pointer.
module diffl_delay
  import fxp_pkg::*;
#(
  parameter int DW    = 17,
  parameter int DELAY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int PTR_W = clog2(DELAY);

  logic [DW-1:0]    mem [DELAY];
  logic [PTR_W-1:0] wr_ptr;

  assign dout = mem[wr_ptr];

  // Clear wins over a write; otherwise a write replaces the oldest entry and
  // the pointer wraps from DELAY-1 back to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < DELAY; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      for (int i = 0; i < DELAY; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= din;
      if (wr_ptr == PTR_W'(DELAY - 1)) begin
        wr_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/diffl.sv
// Modular differentiator (comb stage): Q = D[n] - D[n-DELAY] modulo
// 2^(WIDTH+1), or the reverse difference when add_sub is set. Inverse of the
// accumulator; results before priming use a zero history.
module diffl
  import fxp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DELAY = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clr,
  input  logic           add_sub,
  input  logic           in_valid,
  input  logic [WIDTH:0] D,
  output logic           out_valid,
  output logic [WIDTH:0] Q,
  output logic           primed
);

  localparam int CNT_W = clog2(DELAY + 1);

  diffl_state_t   state;
  diffl_state_t   state_next;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] fill_next;
  logic           accept;
  logic [WIDTH:0] hist;
  logic [WIDTH:0] diff;

  assign accept = in_valid & ~clr;

  diffl_delay #(
    .DW   (WIDTH + 1),
    .DELAY(DELAY)
  ) u_delay (
    .clock(clock),
    .reset(reset),
    .clr  (clr),
    .wr_en(accept),
    .din  (D),
    .dout (hist)
  );

  // Wrapping difference of the incoming sample against the delayed one.
  always_comb begin
    diff = D - hist;
    if (add_sub) begin
      diff = hist - D;
    end
  end

  // Fill count saturates at DELAY; the FSM follows it from EMPTY to PRIMED.
  always_comb begin
    state_next = state;
    fill_next  = fill_cnt;
    if (clr) begin
      state_next = EMPTY;
      fill_next  = '0;
    end else if (accept) begin
      if (fill_cnt != CNT_W'(DELAY)) begin
        fill_next = fill_cnt + CNT_W'(1);
      end
      unique case (state)
        EMPTY:   state_next = (DELAY == 1) ? PRIMED : FILLING;
        FILLING: begin
          if (fill_next == CNT_W'(DELAY)) begin
            state_next = PRIMED;
          end
        end
        default: state_next = PRIMED;
      endcase
    end
  end

  // State and fill count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      fill_cnt <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_next;
    end
  end

  // Result register: one-cycle valid pulse per accepted sample, Q holds otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Q         <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      Q         <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      Q         <= diff;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign primed = (state == PRIMED);

endmodule

// File: tb/tb_diffl.sv
// Bench for diffl: one instance with DELAY=1 and one with DELAY=4, checked
// against a sample-history model and an accumulator loopback model.
module tb_diffl;

  logic        clock = 1'b0;
  logic        reset;
  logic        clr1, add_sub1, in_valid1, out_valid1, primed1;
  logic [16:0] d1, q1;
  logic        clr4, add_sub4, in_valid4, out_valid4, primed4;
  logic [16:0] d4, q4;

  int compared   = 0;
  int mismatched = 0;

  logic [16:0] hist1[$];
  logic [16:0] hist4[$];
  logic [16:0] exp_q1, exp_q4;
  bit          exp_ov1, exp_ov4;

  always #5 clock = ~clock;

  diffl #(.WIDTH(16), .DELAY(1)) dut1 (
    .clock(clock), .reset(reset), .clr(clr1), .add_sub(add_sub1),
    .in_valid(in_valid1), .D(d1), .out_valid(out_valid1), .Q(q1), .primed(primed1)
  );

  diffl #(.WIDTH(16), .DELAY(4)) dut4 (
    .clock(clock), .reset(reset), .clr(clr4), .add_sub(add_sub4),
    .in_valid(in_valid4), .D(d4), .out_valid(out_valid4), .Q(q4), .primed(primed4)
  );

  // Model: remember every accepted sample since the last clear; the delayed
  // sample is the one dly positions back, or zero if there are not enough.
  function automatic void model_edge(int dly, bit c, bit v, bit as, logic [16:0] d);
    logic [16:0] h;
    int n;
    if (dly == 1) begin
      if (c) begin
        hist1.delete(); exp_q1 = '0; exp_ov1 = 0;
      end else if (v) begin
        n = hist1.size();
        h = (n >= 1) ? hist1[n-1] : 17'd0;
        hist1.push_back(d);
        exp_q1 = as ? h - d : d - h; exp_ov1 = 1;
      end else exp_ov1 = 0;
    end else begin
      if (c) begin
        hist4.delete(); exp_q4 = '0; exp_ov4 = 0;
      end else if (v) begin
        n = hist4.size();
        h = (n >= 4) ? hist4[n-4] : 17'd0;
        hist4.push_back(d);
        exp_q4 = as ? h - d : d - h; exp_ov4 = 1;
      end else exp_ov4 = 0;
    end
  endfunction

  function automatic void model_reset();
    hist1.delete(); hist4.delete();
    exp_q1 = '0; exp_q4 = '0; exp_ov1 = 0; exp_ov4 = 0;
  endfunction

  // Apply one cycle of inputs to both instances and advance the model.
  task automatic drive(input bit c1, input bit v1, input bit as1, input logic [16:0] dd1,
                       input bit c4, input bit v4, input bit as4, input logic [16:0] dd4);
    clr1 = c1; in_valid1 = v1; add_sub1 = as1; d1 = dd1;
    clr4 = c4; in_valid4 = v4; add_sub4 = as4; d4 = dd4;
    model_edge(1, c1, v1, as1, dd1);
    model_edge(4, c4, v4, as4, dd4);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if ({q1, out_valid1, primed1} !== 19'd0) begin
      mismatched++; $display("[TB] FAIL reset_d1: got q=%0d ov=%0b pr=%0b expected all 0", q1, out_valid1, primed1);
    end
    compared++;
    if ({q4, out_valid4, primed4} !== 19'd0) begin
      mismatched++; $display("[TB] FAIL reset_d4: got q=%0d ov=%0b pr=%0b expected all 0", q4, out_valid4, primed4);
    end
  endtask

  task automatic test_ramp();
    int vals[3] = '{10000, 20000, 30000};
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 17'(vals[i]), 0, 0, 0, 0);
      compared++;
      if (q1 !== 17'd10000 || out_valid1 !== 1'b1 || primed1 !== 1'b1) begin
        mismatched++; $display("[TB] FAIL ramp[%0d]: got q=%0d ov=%0b pr=%0b expected q=10000 ov=1 pr=1", i, q1, out_valid1, primed1);
      end
    end
    drive(0, 0, 0, 17'd555, 0, 0, 0, 0);
    compared++;
    if (q1 !== 17'd10000 || out_valid1 !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ramp_idle: got q=%0d ov=%0b expected q=10000 ov=0", q1, out_valid1);
    end
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 17'd130000, 0, 0, 0, 0);
    compared++;
    if (q1 !== 17'd130000) begin
      mismatched++; $display("[TB] FAIL wrap_first: got %0d expected 130000", q1);
    end
    drive(0, 1, 0, 17'd8928, 0, 0, 0, 0);
    compared++;
    if (q1 !== 17'd10000) begin
      mismatched++; $display("[TB] FAIL wrap_second: got %0d expected 10000", q1);
    end
  endtask

  task automatic test_subtract();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 17'd10000, 0, 0, 0, 0);
    compared++;
    if (q1 !== 17'd121072) begin
      mismatched++; $display("[TB] FAIL sub_first: got %0d expected 121072", q1);
    end
    drive(0, 1, 1, 17'd20000, 0, 0, 0, 0);
    compared++;
    if (q1 !== 17'd121072) begin
      mismatched++; $display("[TB] FAIL sub_second: got %0d expected 121072", q1);
    end
  endtask

  task automatic test_gaps();
    int expq[8] = '{0, 1, 2, 3, 4, 4, 4, 4};
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 17'(i));
      compared++;
      if (q4 !== 17'(expq[i]) || out_valid4 !== 1'b1 || primed4 !== (i >= 3)) begin
        mismatched++; $display("[TB] FAIL gaps[%0d]: got q=%0d ov=%0b pr=%0b expected q=%0d ov=1 pr=%0b", i, q4, out_valid4, primed4, expq[i], i >= 3);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 17'd99);
      compared++;
      if (q4 !== 17'(expq[i]) || out_valid4 !== 1'b0) begin
        mismatched++; $display("[TB] FAIL gaps_idle[%0d]: got q=%0d ov=%0b expected q=%0d ov=0", i, q4, out_valid4, expq[i]);
      end
    end
  endtask

  task automatic test_clr_collision();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 17'd50000, 0, 0, 0, 0);
    drive(1, 1, 0, 17'd60000, 0, 0, 0, 0);
    compared++;
    if (q1 !== 17'd0 || out_valid1 !== 1'b0 || primed1 !== 1'b0) begin
      mismatched++; $display("[TB] FAIL clr_collision: got q=%0d ov=%0b pr=%0b expected 0/0/0", q1, out_valid1, primed1);
    end
    drive(0, 1, 0, 17'd70000, 0, 0, 0, 0);
    compared++;
    if (q1 !== 17'd70000 || out_valid1 !== 1'b1 || primed1 !== 1'b1) begin
      mismatched++; $display("[TB] FAIL clr_after: got q=%0d ov=%0b pr=%0b expected q=70000 ov=1 pr=1", q1, out_valid1, primed1);
    end
  endtask

  // An accumulator feeding the DELAY=1 instance must be undone sample by sample.
  task automatic test_loopback();
    int steps[3] = '{10000, 5000, 2000};
    logic [16:0] acc, step;
    bit v;
    acc = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        acc = '0;
        drive(1, 1, 0, 17'($urandom), 0, 0, 0, 0);
        compared++;
        if (q1 !== 17'd0 || out_valid1 !== 1'b0) begin
          mismatched++; $display("[TB] FAIL loop_clr[%0d]: got q=%0d ov=%0b expected 0/0", i, q1, out_valid1);
        end
      end else begin
        v = ($urandom_range(0, 3) != 0);
        step = 17'(steps[$urandom_range(0, 2)]);
        if (v) acc = acc + step;
        drive(0, v, 0, acc, 0, 0, 0, 0);
        compared++;
        if (out_valid1 !== v || (v && q1 !== step)) begin
          mismatched++; $display("[TB] FAIL loop[%0d]: got q=%0d ov=%0b expected q=%0d ov=%0b", i, q1, out_valid1, step, v);
        end
      end
    end
  endtask

  task automatic test_random();
    bit c1, v1, a1, c4, v4, a4;
    for (int i = 0; i < 300; i++) begin
      c1 = ($urandom_range(0, 24) == 0); v1 = $urandom_range(0, 1); a1 = $urandom_range(0, 1);
      c4 = ($urandom_range(0, 24) == 0); v4 = $urandom_range(0, 1); a4 = $urandom_range(0, 1);
      drive(c1, v1, a1, 17'($urandom), c4, v4, a4, 17'($urandom));
      compared++;
      if (q1 !== exp_q1 || out_valid1 !== exp_ov1 || primed1 !== (hist1.size() >= 1)) begin
        mismatched++; $display("[TB] FAIL rand_d1[%0d]: got q=%0d ov=%0b pr=%0b expected q=%0d ov=%0b pr=%0b", i, q1, out_valid1, primed1, exp_q1, exp_ov1, hist1.size() >= 1);
      end
      compared++;
      if (q4 !== exp_q4 || out_valid4 !== exp_ov4 || primed4 !== (hist4.size() >= 4)) begin
        mismatched++; $display("[TB] FAIL rand_d4[%0d]: got q=%0d ov=%0b pr=%0b expected q=%0d ov=%0b pr=%0b", i, q4, out_valid4, primed4, exp_q4, exp_ov4, hist4.size() >= 4);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 17'(1000 * (i + 1)), 0, 1, 0, 17'(3000 * (i + 1)));
    end
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if ({q1, out_valid1, primed1} !== 19'd0 || {q4, out_valid4, primed4} !== 19'd0) begin
      mismatched++; $display("[TB] FAIL reset_async: got d1 q=%0d ov=%0b pr=%0b d4 q=%0d ov=%0b pr=%0b expected all 0", q1, out_valid1, primed1, q4, out_valid4, primed4);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 17'd777, 0, 0, 0, 17'd777);
    compared++;
    if ({q1, out_valid1, primed1} !== 19'd0 || {q4, out_valid4, primed4} !== 19'd0) begin
      mismatched++; $display("[TB] FAIL reset_release: got d1 q=%0d ov=%0b d4 q=%0d ov=%0b expected all 0", q1, out_valid1, q4, out_valid4);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset = 1'b0;
    clr1 = 0; in_valid1 = 0; add_sub1 = 0; d1 = '0;
    clr4 = 0; in_valid4 = 0; add_sub4 = 0; d4 = '0;
    test_reset();
    test_ramp();
    test_wrap();
    test_subtract();
    test_gaps();
    test_clr_collision();
    test_loopback();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
